response_filter: RTL and testbench
==================================

// Module: response_filter
// PURPOSE
//  Sits between shared_resource and consumer. Tracks every request the arbiter grants, by ID.
//  Discards responses whose request was flushed by its source pipeline while outstanding.
//  Buffers surviving responses in a small FIFO and delivers them to the consumer over valid/ready.
//  Tags each delivered response with its source pipeline.
// PARAMETERS
//  DATA_WIDTH  32  response data width (matches `DATA_WIDTH)
//  ID_WIDTH    4   request ID width (matches `ID_WIDTH); tracking table has 2**ID_WIDTH entries
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1           clock, all state on posedge
//  reset        in   1           asynchronous, active-low (0 = reset)
//  issue_valid  in   1           arbiter granted a request to the resource this cycle
//  issue_id     in   ID_WIDTH    ID of the granted request
//  issue_src    in   1           0 = pipeline_1, 1 = pipeline_2 (arbiter_choice)
//  flush_1      in   1           pipeline_1 flush strobe
//  flush_id_1   in   ID_WIDTH    ID flushed by pipeline_1
//  flush_2      in   1           pipeline_2 flush strobe
//  flush_id_2   in   ID_WIDTH    ID flushed by pipeline_2
//  in_data      in   DATA_WIDTH  resource response data
//  in_id        in   ID_WIDTH    resource response ID
//  in_valid     in   1           resource response valid; no backpressure possible
//  out_data     out  DATA_WIDTH  FIFO head data
//  out_id       out  ID_WIDTH    FIFO head ID
//  out_src      out  1           FIFO head source pipeline
//  out_valid    out  1           FIFO non-empty
//  in_ready     in   1           consumer accepts head when out_valid && in_ready
//  drop_count   out  8           saturating count of flushed responses discarded
//  err_overflow out  1           sticky; a surviving response was lost because the FIFO was full
//  err_orphan   out  1           sticky; a response arrived for an ID with no outstanding entry
//  err_dup      out  1           sticky; issue_id was already outstanding when issued
// BEHAVIOUR
//  Reset (reset==0, async): table cleared (busy=0, killed=0); FIFO empty.
//   All outputs 0: out_valid, drop_count, err_* and out_data/out_id/out_src.
//  Table entry [id] = {busy, src, killed}.
//  - Issue: on issue_valid, entry <= {1, issue_src, 0}. If already busy, set err_dup and overwrite.
//  - Flush: on flush_k, kill the entry only if busy and src matches pipeline k. Mismatch or idle = no-op.
//    flush_1 and flush_2 in the same cycle are both applied.
//  - Response: on in_valid, look up entry [in_id] and clear busy.
//    !busy -> drop and set err_orphan; drop_count unchanged.
//    killed, or killed by a same-cycle matching flush -> drop; drop_count+1, saturating at 255.
//    otherwise -> push {in_data, in_id, src}.
//  - Same-ID same-cycle priority:
//    response vs issue: the response sees the old entry, then the issue writes the new one.
//    issue vs flush: the issue wins and the entry is not killed.
//  FIFO: registered, first-word fall-through. out_* reflect the head combinationally from storage.
//   Response in cycle N -> out_valid in N+1 (minimum latency 1).
//   Pop when out_valid && in_ready.
//   Push while full is accepted only if a pop happens the same cycle.
//   Otherwise the response is lost and err_overflow is set.
//   Read/write pointers carry an extra wrap bit; full when indices match and wrap bits differ.
//  Reset mid-operation discards every outstanding entry and every buffered response.
// TESTING
//  1. Issue id=3 src=0; response id=3 data=0xA5 two cycles later, in_ready=1
//     -> out_valid one cycle after the response, out_data=0xA5, out_id=3, out_src=0.
//  2. Issue id=5 src=1; flush_2 id=5; then response id=5 -> no out_valid, drop_count=1.
//     Repeat with flush_1 id=5 instead -> response delivered.
//  3. Response id=7 in the same cycle as flush_2 id=7 (outstanding, src=1)
//     -> dropped, drop_count+1; err_orphan stays 0.
//  4. in_ready=0; 5 responses to outstanding IDs on consecutive cycles
//     -> 4 buffered, err_overflow=1, FIFO order preserved after in_ready=1.
//  5. Response id=9 with no issue -> err_orphan=1, no out_valid.
//     Issue id=2 twice -> err_dup=1.
//  6. Assert reset low mid-stream with 2 buffered and 3 outstanding
//     -> out_valid=0 immediately; post-reset response to an old ID -> err_orphan=1.

Source files
------------

// File: rtl/response_filter.sv
// Tracks granted requests by ID, discards responses of flushed requests and
// delivers surviving responses, tagged with their source pipeline, through a small FWFT FIFO.
module response_filter #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [ID_WIDTH-1:0]   issue_id,
    input  logic                  issue_src,
    input  logic                  flush_1,
    input  logic [ID_WIDTH-1:0]   flush_id_1,
    input  logic                  flush_2,
    input  logic [ID_WIDTH-1:0]   flush_id_2,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic                  out_src,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [7:0]            drop_count,
    output logic                  err_overflow,
    output logic                  err_orphan,
    output logic                  err_dup
);

    localparam int ENTRIES = 1 << ID_WIDTH;
    localparam int AW      = $clog2(FIFO_DEPTH);

    logic [ENTRIES-1:0] busy_reg,   busy_next;
    logic [ENTRIES-1:0] src_reg,    src_next;
    logic [ENTRIES-1:0] killed_reg, killed_next;

    // Per-entry update: flush kills, response retires, issue overwrites last.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic kill_1;
            logic kill_2;
            assign kill_1 = flush_1 && (flush_id_1 == ID_WIDTH'(gi)) && busy_reg[gi] && !src_reg[gi];
            assign kill_2 = flush_2 && (flush_id_2 == ID_WIDTH'(gi)) && busy_reg[gi] &&  src_reg[gi];

            always_comb begin
                busy_next[gi]   = busy_reg[gi];
                src_next[gi]    = src_reg[gi];
                killed_next[gi] = killed_reg[gi];
                if (kill_1 || kill_2) begin
                    killed_next[gi] = 1'b1;
                end
                if (in_valid && (in_id == ID_WIDTH'(gi))) begin
                    busy_next[gi] = 1'b0;
                end
                if (issue_valid && (issue_id == ID_WIDTH'(gi))) begin
                    busy_next[gi]   = 1'b1;
                    src_next[gi]    = issue_src;
                    killed_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg   <= '0;
            src_reg    <= '0;
            killed_reg <= '0;
        end else begin
            busy_reg   <= busy_next;
            src_reg    <= src_next;
            killed_reg <= killed_next;
        end
    end

    // Response classification against the pre-update entry plus same-cycle flushes.
    logic rsp_busy;
    logic rsp_src;
    logic rsp_killed;
    logic rsp_orphan;
    logic rsp_drop;
    logic rsp_push;
    logic issue_dup;

    assign rsp_busy   = busy_reg[in_id];
    assign rsp_src    = src_reg[in_id];
    assign rsp_killed = killed_reg[in_id]
                      || (flush_1 && (flush_id_1 == in_id) && !rsp_src)
                      || (flush_2 && (flush_id_2 == in_id) &&  rsp_src);
    assign rsp_orphan = in_valid && !rsp_busy;
    assign rsp_drop   = in_valid && rsp_busy && rsp_killed;
    assign rsp_push   = in_valid && rsp_busy && !rsp_killed;
    // A request retired by a same-cycle response is not counted as a duplicate.
    assign issue_dup  = issue_valid && busy_reg[issue_id] && !(in_valid && (in_id == issue_id));

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   id_mem   [FIFO_DEPTH];
    logic                  src_mem  [FIFO_DEPTH];

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_pop;
    logic        fifo_push;
    logic        fifo_lost;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign fifo_pop   = !fifo_empty && in_ready;
    assign fifo_push  = rsp_push && (!fifo_full || fifo_pop);
    assign fifo_lost  = rsp_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            data_mem[wr_ptr_reg[AW-1:0]] <= in_data;
            id_mem[wr_ptr_reg[AW-1:0]]   <= in_id;
            src_mem[wr_ptr_reg[AW-1:0]]  <= rsp_src;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            drop_count   <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
            err_dup      <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (rsp_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (fifo_lost) begin
                err_overflow <= 1'b1;
            end
            if (rsp_orphan) begin
                err_orphan <= 1'b1;
            end
            if (issue_dup) begin
                err_dup <= 1'b1;
            end
        end
    end

    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? data_mem[rd_ptr_reg[AW-1:0]] : '0;
    assign out_id    = out_valid ? id_mem[rd_ptr_reg[AW-1:0]]   : '0;
    assign out_src   = out_valid ? src_mem[rd_ptr_reg[AW-1:0]]  : 1'b0;

endmodule

// File: tb/tb_response_filter.sv
// Directed bench for response_filter: a queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_response_filter;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue_valid = 1'b0;
    logic [IW-1:0] issue_id = '0;
    logic          issue_src = 1'b0;
    logic          flush_1 = 1'b0;
    logic [IW-1:0] flush_id_1 = '0;
    logic          flush_2 = 1'b0;
    logic [IW-1:0] flush_id_2 = '0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] in_id = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;
    logic          out_src;
    logic          out_valid;
    logic          in_ready = 1'b0;
    logic [7:0]    drop_count;
    logic          err_overflow;
    logic          err_orphan;
    logic          err_dup;

    response_filter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_id(issue_id), .issue_src(issue_src),
        .flush_1(flush_1), .flush_id_1(flush_id_1), .flush_2(flush_2), .flush_id_2(flush_id_2),
        .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
        .out_data(out_data), .out_id(out_id), .out_src(out_src), .out_valid(out_valid),
        .in_ready(in_ready), .drop_count(drop_count),
        .err_overflow(err_overflow), .err_orphan(err_orphan), .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: outstanding-request table and an ordered queue of deliverable responses.
    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          s;
    } ent_t;

    bit   m_busy   [16];
    bit   m_src    [16];
    bit   m_killed [16];
    ent_t m_q[$];
    int   m_drops;
    bit   m_ovf, m_orph, m_dup;

    always @(posedge clk or negedge reset) begin : model
        bit ob [16];
        bit os [16];
        bit ok [16];
        bit killed_now;
        ent_t e;
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                m_busy[i] = 0; m_src[i] = 0; m_killed[i] = 0;
            end
            m_q.delete();
            m_drops = 0; m_ovf = 0; m_orph = 0; m_dup = 0;
        end else begin
            ob = m_busy; os = m_src; ok = m_killed;
            if (m_q.size() > 0 && in_ready) void'(m_q.pop_front());
            if (in_valid) begin
                if (!ob[in_id]) begin
                    m_orph = 1;
                end else begin
                    killed_now = ok[in_id]
                        || (flush_1 && flush_id_1 == in_id && os[in_id] == 1'b0)
                        || (flush_2 && flush_id_2 == in_id && os[in_id] == 1'b1);
                    if (killed_now) begin
                        if (m_drops < 255) m_drops++;
                    end else begin
                        e.d = in_data; e.id = in_id; e.s = os[in_id];
                        if (m_q.size() < DEPTH) m_q.push_back(e);
                        else m_ovf = 1;
                    end
                end
            end
            if (issue_valid && ob[issue_id] && !(in_valid && in_id == issue_id)) m_dup = 1;
            if (flush_1 && ob[flush_id_1] && os[flush_id_1] == 1'b0) m_killed[flush_id_1] = 1;
            if (flush_2 && ob[flush_id_2] && os[flush_id_2] == 1'b1) m_killed[flush_id_2] = 1;
            if (in_valid) m_busy[in_id] = 0;
            if (issue_valid) begin
                m_busy[issue_id] = 1; m_src[issue_id] = issue_src; m_killed[issue_id] = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out_data", 64'(out_data), 64'(m_q[0].d));
            check("out_id",   64'(out_id),   64'(m_q[0].id));
            check("out_src",  64'(out_src),  64'(m_q[0].s));
        end else begin
            check("out_data_idle", 64'(out_data), 64'd0);
        end
        check("drop_count",   64'(drop_count),   64'(m_drops));
        check("err_overflow", 64'(err_overflow), 64'(m_ovf));
        check("err_orphan",   64'(err_orphan),   64'(m_orph));
        check("err_dup",      64'(err_dup),      64'(m_dup));
    end

    // Inputs set beforehand are sampled at the next edge, then strobes are cleared.
    task automatic step();
        @(posedge clk);
        #1;
        issue_valid = 0; flush_1 = 0; flush_2 = 0; in_valid = 0;
    endtask

    task automatic issue(input int id, input bit src);
        issue_valid = 1; issue_id = IW'(id); issue_src = src;
    endtask

    task automatic respond(input int id, input logic [DW-1:0] d);
        in_valid = 1; in_id = IW'(id); in_data = d;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        step(); step();
        reset = 1'b1;
        step();

        // 1: basic delivery, one-cycle latency
        in_ready = 1;
        issue(3, 0); step();
        step();
        respond(3, 32'hA5); step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data",  64'(out_data),  64'hA5);
        check("t1_id",    64'(out_id),    64'd3);
        check("t1_src",   64'(out_src),   64'd0);
        step();
        check("t1_popped", 64'(out_valid), 64'd0);

        // 2: matching flush drops, mismatched flush is ignored
        issue(5, 1); step();
        flush_2 = 1; flush_id_2 = 4'd5; step();
        respond(5, 32'h11); step();
        check("t2_novalid", 64'(out_valid), 64'd0);
        check("t2_drops",   64'(drop_count), 64'd1);
        issue(5, 1); step();
        flush_1 = 1; flush_id_1 = 4'd5; step();
        respond(5, 32'h55); step();
        check("t2b_valid", 64'(out_valid), 64'd1);
        check("t2b_data",  64'(out_data),  64'h55);
        check("t2b_src",   64'(out_src),   64'd1);
        step();

        // 3: flush in the same cycle as the response
        issue(7, 1); step();
        respond(7, 32'h77); flush_2 = 1; flush_id_2 = 4'd7; step();
        check("t3_drops",  64'(drop_count), 64'd2);
        check("t3_orphan", 64'(err_orphan), 64'd0);
        check("t3_novalid", 64'(out_valid), 64'd0);

        // 4: overflow with backpressure, then drain in order
        in_ready = 0;
        for (int i = 10; i < 15; i++) begin
            issue(i, i[0]); step();
        end
        for (int i = 10; i < 15; i++) begin
            respond(i, 32'h100 + 32'(i)); step();
            if (i == 13) check("t4_no_ovf_yet", 64'(err_overflow), 64'd0);
        end
        check("t4_overflow", 64'(err_overflow), 64'd1);
        in_ready = 1;
        for (int i = 10; i < 14; i++) begin
            #1;
            check("t4_order", 64'(out_data), 64'(32'h100 + 32'(i)));
            step();
        end
        check("t4_drained", 64'(out_valid), 64'd0);

        // 5: orphan response and duplicate issue
        respond(9, 32'h99); step();
        check("t5_orphan", 64'(err_orphan), 64'd1);
        check("t5_novalid", 64'(out_valid), 64'd0);
        issue(2, 0); step();
        check("t5_nodup", 64'(err_dup), 64'd0);
        issue(2, 1); step();
        check("t5_dup", 64'(err_dup), 64'd1);

        // 6: reset mid-stream with 2 buffered and 3 outstanding (2, 1, 4)
        in_ready = 0;
        issue(1, 0); step();
        issue(4, 1); step();
        issue(8, 0); step();
        issue(11, 1); step();
        respond(8, 32'h88); step();
        respond(11, 32'hBB); step();
        check("t6_buffered", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid",  64'(out_valid),  64'd0);
        check("t6_rst_orphan", 64'(err_orphan), 64'd0);
        check("t6_rst_dup",    64'(err_dup),    64'd0);
        check("t6_rst_drops",  64'(drop_count), 64'd0);
        step();
        reset = 1'b1;
        step();
        respond(1, 32'h1234); step();
        check("t6_orphan", 64'(err_orphan), 64'd1);
        check("t6_novalid", 64'(out_valid), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
